// File: rtl/config_chain_loader.sv
// Serialises configuration words LSB-first into a tile configuration shift chain.
// Optional CRC-16-CCITT check of the shifted stream is enabled by defining CONFIG_LOADER_CRC_EN.
module config_chain_loader #(
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned CHAIN_LENGTH = 1152
) (
    input  logic                  config_clock,
    input  logic                  config_reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  chain_data,
    output logic                  config_enable,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CntW = $clog2(CHAIN_LENGTH + 1);
    localparam int unsigned IdxW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StCheck,
        StDone
    } state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [IdxW-1:0]       bit_idx_q, bit_idx_d;
    logic                  chain_data_q, chain_data_d;
    logic                  error_q, error_d;
    logic                  word_ready_q;
    logic                  config_enable_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ready_d;

`ifdef CONFIG_LOADER_CRC_EN
    logic [15:0] crc_q, crc_d;
    logic        crc_fb;
`endif

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        bit_cnt_d    = bit_cnt_q;
        bit_idx_d    = bit_idx_q;
        chain_data_d = 1'b0;
        error_d      = error_q;
`ifdef CONFIG_LOADER_CRC_EN
        crc_d        = crc_q;
        crc_fb       = crc_q[15] ^ chain_data_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StFetch;
                    bit_cnt_d = '0;
                    bit_idx_d = '0;
                    error_d   = 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
                    crc_d     = 16'hFFFF;
`endif
                end
            end
            StFetch: begin
                if (word_valid && word_ready_q) begin
                    state_d      = StShift;
                    chain_data_d = word_data[0];
                    shreg_d      = word_data >> 1;
                    bit_idx_d    = '0;
                end
            end
            StShift: begin
`ifdef CONFIG_LOADER_CRC_EN
                crc_d = {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
`endif
                bit_cnt_d = bit_cnt_q + CntW'(1);
                // Chain full takes priority: remaining upper bits of the word are dropped.
                if (bit_cnt_d == CntW'(CHAIN_LENGTH)) begin
                    state_d = StCheck;
                end else if (bit_idx_q == IdxW'(WORD_WIDTH - 1)) begin
                    state_d = StFetch;
                end else begin
                    bit_idx_d    = bit_idx_q + IdxW'(1);
                    chain_data_d = shreg_q[0];
                    shreg_d      = shreg_q >> 1;
                end
            end
            StCheck: begin
`ifdef CONFIG_LOADER_CRC_EN
                if (word_valid && word_ready_q) begin
                    error_d = (word_data[15:0] != crc_q);
                    state_d = StDone;
                end
`else
                state_d = StDone;
`endif
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

`ifdef CONFIG_LOADER_CRC_EN
    assign ready_d = (state_d == StFetch) || (state_d == StCheck);
`else
    assign ready_d = (state_d == StFetch);
`endif

    // Outputs are registered from the next state so they line up with state_q.
    always_ff @(posedge config_clock) begin
        if (config_reset) begin
            state_q         <= StIdle;
            shreg_q         <= '0;
            bit_cnt_q       <= '0;
            bit_idx_q       <= '0;
            chain_data_q    <= 1'b0;
            error_q         <= 1'b0;
            word_ready_q    <= 1'b0;
            config_enable_q <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
`ifdef CONFIG_LOADER_CRC_EN
            crc_q           <= 16'hFFFF;
`endif
        end else begin
            state_q         <= state_d;
            shreg_q         <= shreg_d;
            bit_cnt_q       <= bit_cnt_d;
            bit_idx_q       <= bit_idx_d;
            chain_data_q    <= chain_data_d;
            error_q         <= error_d;
            word_ready_q    <= ready_d;
            config_enable_q <= (state_d == StShift);
            busy_q          <= (state_d != StIdle);
            done_q          <= (state_d == StDone);
`ifdef CONFIG_LOADER_CRC_EN
            crc_q           <= crc_d;
`endif
        end
    end

    assign word_ready    = word_ready_q;
    assign chain_data    = chain_data_q;
    assign config_enable = config_enable_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

endmodule

// File: tb/tb_config_chain_loader.sv
// Scoreboard bench for config_chain_loader (WORD_WIDTH=32, CHAIN_LENGTH=36).
// Expected chain bits and done/error results are queued by stimulus and consumed by a monitor.
module tb_config_chain_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] word_data;
    logic        word_valid;
    logic        word_ready;
    logic        chain_data;
    logic        config_enable;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int en_cnt = 0;
    int done_cnt = 0;

    logic exp_q[$];
    logic err_q[$];

    config_chain_loader #(
        .WORD_WIDTH  (32),
        .CHAIN_LENGTH(36)
    ) dut (
        .config_clock (clk),
        .config_reset (rst),
        .start        (start),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .chain_data   (chain_data),
        .config_enable(config_enable),
        .busy         (busy),
        .done         (done),
        .error        (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every shifted bit and every done pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (config_enable) begin
            en_cnt++;
            if (exp_q.size() == 0) begin
                chk("extra_shift", 32'(chain_data) | 32'h100, 32'(chain_data));
            end else begin
                logic b;
                b = exp_q.pop_front();
                chk("chain_bit", 32'(chain_data), 32'(b));
            end
        end
        if (done) begin
            done_cnt++;
            chk("busy_in_done", 32'(busy), 32'd1);
            if (err_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                logic e;
                e = err_q.pop_front();
                chk("done_error", 32'(error), 32'(e));
            end
        end
    end

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_word_ready"}, 32'(word_ready), 32'd0);
        chk({tag, "_config_enable"}, 32'(config_enable), 32'd0);
        chk({tag, "_chain_data"}, 32'(chain_data), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (word_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("word_ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    function automatic logic [15:0] crc_of(input logic [35:0] bits);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 36; i++) begin
            fb = c[15] ^ bits[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // One full load; exp_bits[i] is the i-th bit that must appear on chain_data.
    task automatic run_load(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                            input int nwords, input logic [35:0] exp_bits, input logic exp_err,
                            input int gap, input bit restart);
        logic [31:0] w[3];
        bit          ok;
        w[0] = w0;
        w[1] = w1;
        w[2] = w2;
        for (int i = 0; i < 36; i++) exp_q.push_back(exp_bits[i]);
        err_q.push_back(exp_err);
        en_cnt   = 0;
        done_cnt = 0;
        pulse_start();
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("error_cleared_on_start", 32'(error), 32'd0);
        for (int k = 0; k < nwords; k++) begin
            word_data  = w[k];
            word_valid = 1'b1;
            wait_ready(ok);
            if (!ok) begin
                word_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1 word_valid = 1'b0;
            word_data = 32'hDEAD_BEEF;
            if (k == 0 && restart) begin
                repeat (3) @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            if (k == 0 && gap > 0) begin
                wait_ready(ok);
                chk("stall_enable", 32'(config_enable), 32'd0);
                for (int g = 1; g < gap; g++) begin
                    @(negedge clk);
                    chk("stall_enable", 32'(config_enable), 32'd0);
                    chk("stall_ready", 32'(word_ready), 32'd1);
                end
                @(posedge clk);
                #1;
            end
        end
        ok = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("idle_after_done", 32'(busy), 32'd0);
        chk("enable_cycles", 32'(en_cnt), 32'd36);
        chk("done_pulses", 32'(done_cnt), 32'd1);
        chk("bits_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit ok;
        rst        = 1'b1;
        start      = 1'b0;
        word_valid = 1'b0;
        word_data  = '0;
        repeat (3) @(posedge clk);
        #1 check_idle_outputs("reset");
        rst = 1'b0;

`ifdef CONFIG_LOADER_CRC_EN
        run_load(32'h0000_000F, 32'h0000_0005, 32'(crc_of(36'h5_0000_000F)), 3,
                 36'h5_0000_000F, 1'b0, 0, 1'b0);
        run_load(32'hA5A5_3C3C, 32'hFFFF_FFF6, 32'(crc_of(36'h6_A5A5_3C3C) ^ 16'h0001), 3,
                 36'h6_A5A5_3C3C, 1'b1, 0, 1'b0);
        repeat (5) @(negedge clk);
        chk("error_sticky", 32'(error), 32'd1);
        @(posedge clk);
        #1;
        run_load(32'h0000_000F, 32'h0000_0005, 32'(crc_of(36'h5_0000_000F)), 3,
                 36'h5_0000_000F, 1'b0, 5, 1'b1);
`else
        // Basic two-word load, then a second pattern whose dropped upper bits are all ones.
        run_load(32'h0000_000F, 32'h0000_0005, 32'h0, 2, 36'h5_0000_000F, 1'b0, 0, 1'b0);
        run_load(32'hA5A5_3C3C, 32'hFFFF_FFF6, 32'h0, 2, 36'h6_A5A5_3C3C, 1'b0, 0, 1'b0);
        run_load(32'h0000_000F, 32'h0000_0005, 32'h0, 2, 36'h5_0000_000F, 1'b0, 5, 1'b0);
        run_load(32'h1234_5678, 32'h0000_0009, 32'h0, 2, 36'h9_1234_5678, 1'b0, 0, 1'b1);
        repeat (4) @(negedge clk);
        chk("no_crc_word_ready", 32'(word_ready), 32'd0);
        @(posedge clk);
        #1;
`endif

        // Reset in the middle of a load, after 20 bits have been shifted.
        for (int i = 0; i < 36; i++) exp_q.push_back(1'b1);
        en_cnt = 0;
        pulse_start();
        word_data  = 32'hFFFF_FFFF;
        word_valid = 1'b1;
        wait_ready(ok);
        @(posedge clk);
        #1 word_valid = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #2;
            if (en_cnt == 20) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("bit20_timeout", 32'd0, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 check_idle_outputs("midload_reset");
        rst = 1'b0;
        exp_q.delete();
        err_q.delete();
        @(posedge clk);
        #1;
`ifdef CONFIG_LOADER_CRC_EN
        run_load(32'h0000_000F, 32'h0000_0005, 32'(crc_of(36'h5_0000_000F)), 3,
                 36'h5_0000_000F, 1'b0, 0, 1'b0);
`else
        run_load(32'h0000_000F, 32'h0000_0005, 32'h0, 2, 36'h5_0000_000F, 1'b0, 0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
